// File: rtl/ens_layer_sched_pkg.sv
// ens_layer_sched_pkg: shared widths, default parameters and response entry type
package ens_layer_sched_pkg;
    localparam int DEF_N_REQ = 4;
    localparam int DEF_IN_W  = 8;
    localparam int DEF_OUT_W = 1;
    localparam int DEF_DEPTH = 4;

    function automatic int id_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ID_W = id_w(DEF_N_REQ);

    typedef struct packed {
        logic [DEF_ID_W-1:0]  id;
        logic [DEF_OUT_W-1:0] data;
    } rsp_t;
endpackage

// File: rtl/ens_layer_sched_rsp_fifo.sv
// ens_rsp_fifo: response FIFO, simultaneous read/write, zero output when empty
module ens_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_rd;
    assign empty = count == '0;
    assign do_rd = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rp];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (wr_en) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(do_rd);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wp] <= wr_data;
    end
endmodule

// File: rtl/ens_layer_sched.sv
// ens_layer_sched: round-robin, credit-gated sharing of one combinational layer
// among N_REQ requesters, with an in-order response FIFO.
module ens_layer_sched
    import ens_layer_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*IN_W-1:0]    req_data,
    output logic [IN_W-1:0]          lay_in,
    input  logic [OUT_W-1:0]         lay_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [OUT_W-1:0]         rsp_data,
    output logic [id_w(N_REQ)-1:0]   rsp_id
);
    localparam int ID_W = id_w(N_REQ);
    localparam int CW   = $clog2(DEPTH) + 1;
    logic [ID_W-1:0] ptr, win, s1_id;
    logic hit, s1_valid, credit, grant, empty;
    logic [CW-1:0] count;
    logic [ID_W+OUT_W-1:0] head;
    always_comb begin
        int j;
        j = 0;
        hit = 1'b0;
        win = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            j = j >= N_REQ ? j - N_REQ : j;
            if (!hit && req_valid[j]) begin
                hit = 1'b1;
                win = ID_W'(j);
            end
        end
    end
    // in-flight S1 entry reserves a slot so the FIFO can never be written when full
    assign credit = (count + CW'(s1_valid)) < CW'(DEPTH);
    assign grant = hit && credit && !rst;
    assign req_ready = grant ? N_REQ'(1) << win : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            lay_in <= '0;
            s1_id <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= grant;
            if (grant) begin
                lay_in <= req_data[win*IN_W +: IN_W];
                s1_id <= win;
                ptr <= win == ID_W'(N_REQ-1) ? '0 : win + 1'b1;
            end
        end
    end
    ens_rsp_fifo #(.WIDTH(ID_W+OUT_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .wr_en(s1_valid),
        .wr_data({s1_id, lay_out}),
        .rd_en(rsp_valid && rsp_ready),
        .rd_data(head),
        .empty(empty),
        .count(count)
    );
    assign rsp_valid = !empty;
    assign {rsp_id, rsp_data} = head;
endmodule

// File: tb/tb_ens_layer_sched.sv
// tb_ens_layer_sched: directed checks plus an in-order scoreboard for ens_layer_sched
module tb_ens_layer_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req_valid = '0;
    logic [3:0] req_ready;
    logic [31:0] req_data = '0;
    logic [7:0] lay_in;
    logic [3:0] lay_out;
    logic rsp_valid;
    logic rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic [1:0] rsp_id;
    int tests = 0;
    int fails = 0;
    int grants;
    logic [5:0] q [$];
    logic [5:0] e;

    always #5 clk = ~clk;

    function automatic logic [3:0] lay(input logic [7:0] x);
        return x[3:0] ^ x[7:4];
    endfunction

    assign lay_out = lay(lay_in);

    ens_layer_sched #(.N_REQ(4), .IN_W(8), .OUT_W(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .lay_in(lay_in), .lay_out(lay_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sample handshakes just before the edge, then advance one cycle
    task automatic tick();
        #1;
        chk("onehot", 32'($countones(req_ready) <= 1), 1);
        if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) chk("sb_unexpected", 1, 0);
            else begin
                e = q.pop_front();
                chk("sb_id", 32'(rsp_id), 32'(e[5:4]));
                chk("sb_data", 32'(rsp_data), 32'(e[3:0]));
            end
        end
        for (int i = 0; i < 4; i++)
            if (req_valid[i] && req_ready[i]) q.push_back({2'(i), lay(req_data[i*8 +: 8])});
        if (rst) q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_lay_in", 32'(lay_in), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        tick();
        rst = 1'b0;
        tick();
        // single request from requester 0
        req_valid = 4'b0001;
        req_data = 32'h0000000C;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("single_lay_in", 32'(lay_in), 32'h0C);
        chk("single_early", 32'(rsp_valid), 0);
        tick();
        chk("single_valid", 32'(rsp_valid), 1);
        chk("single_id", 32'(rsp_id), 0);
        chk("single_data", 32'(rsp_data), 32'hC);
        rsp_ready = 1'b1;
        tick();
        chk("single_drained", 32'(rsp_valid), 0);
        // reset returns ptr to 0, then full round robin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        req_data = 32'hA35C710C;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 2) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 1);
                chk("rr_rsp_id", 32'(rsp_id), 32'((k - 2) % 4));
            end
            tick();
        end
        req_valid = '0;
        repeat (4) tick();
        chk("rr_drained", 32'(q.size()), 0);
        // credit exhaustion with blocked output
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        req_data = 32'h00E70000;
        grants = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (req_ready[2]) grants++;
            tick();
        end
        chk("credit_grants", 32'(grants), 4);
        chk("credit_ready0", 32'(req_ready), 0);
        chk("credit_hold_id", 32'(rsp_id), 2);
        chk("credit_hold_data", 32'(rsp_data), 32'h9);
        grants = 0;
        rsp_ready = 1'b1;
        #1;
        if (req_ready[2]) grants++;
        tick();
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (req_ready[2]) grants++;
            tick();
        end
        chk("credit_one_more", 32'(grants), 1);
        chk("full_valid", 32'(rsp_valid), 1);
        // full FIFO draining while new grants keep arriving
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("full_occ", 32'(q.size() <= 4), 1);
        end
        req_valid = '0;
        repeat (8) tick();
        chk("full_drained", 32'(q.size()), 0);
        chk("full_empty", 32'(rsp_valid), 0);
        // reset with 3 buffered entries and S1 occupied
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        req_data = 32'h00003300;
        repeat (4) tick();
        req_valid = '0;
        chk("pre_rst_valid", 32'(rsp_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rsp_valid", 32'(rsp_valid), 0);
        chk("async_ready", 32'(req_ready), 0);
        chk("async_lay_in", 32'(lay_in), 0);
        chk("async_rsp_id", 32'(rsp_id), 0);
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("no_stale", 32'(rsp_valid), 0);
        end
        req_valid = 4'b1010;
        req_data = 32'h5A00C300;
        #1;
        chk("post_rst_first", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        chk("post_rst_lay_in", 32'(lay_in), 32'hC3);
        repeat (4) tick();
        chk("post_rst_drained", 32'(q.size()), 0);
        // random traffic checked by the scoreboard
        for (int k = 0; k < 300; k++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_data = $urandom;
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (10) tick();
        chk("rand_drained", 32'(q.size()), 0);
        chk("rand_empty", 32'(rsp_valid), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
